// File: rtl/zhiwen_pkg.sv
// Shared constants, state encoding and packet helpers for the fingerprint-sensor command transmitter.
package zhiwen_pkg;

  localparam logic [15:0] ZW_HEADER  = 16'hEF01;
  localparam logic [31:0] ZW_ADDR    = 32'hFFFF_FFFF;
  localparam logic [7:0]  ZW_PID_CMD = 8'h01;
  localparam logic [15:0] ZW_CMD_LEN = 16'h0003;

  localparam logic [7:0] CMD_GET_IMAGE = 8'h01;
  localparam logic [7:0] CMD_GEN_CHAR  = 8'h02;
  localparam logic [7:0] CMD_SEARCH    = 8'h04;

  localparam int unsigned PKT_BYTES = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND,
    ST_GAP
  } zw_state_e;

  // Bits needed for a counter running 0 .. num_values-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned num_values);
    return (num_values < 2) ? 1 : $clog2(num_values);
  endfunction

  function automatic logic [15:0] pkt_sum(input logic [7:0] cmd);
    return {8'h00, ZW_PID_CMD} + ZW_CMD_LEN + {8'h00, cmd};
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [7:0] cmd);
    logic [15:0] sum;
    logic [7:0]  b;
    sum = pkt_sum(cmd);
    b   = 8'h00;
    case (idx)
      4'd0:  b = ZW_HEADER[15:8];
      4'd1:  b = ZW_HEADER[7:0];
      4'd2:  b = ZW_ADDR[31:24];
      4'd3:  b = ZW_ADDR[23:16];
      4'd4:  b = ZW_ADDR[15:8];
      4'd5:  b = ZW_ADDR[7:0];
      4'd6:  b = ZW_PID_CMD;
      4'd7:  b = ZW_CMD_LEN[15:8];
      4'd8:  b = ZW_CMD_LEN[7:0];
      4'd9:  b = cmd;
      4'd10: b = sum[15:8];
      4'd11: b = sum[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/zhiwen_cmd_tx_if.sv
// Request/status bundle between the enable logic and the command transmitter.
interface zhiwen_cmd_tx_if;

  logic tx_en;
  logic uart_tx;
  logic busy;
  logic frame_done;

  modport master (
    output tx_en,
    input  uart_tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  tx_en,
    output uart_tx,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; done marks the last clock of the stop bit so a new start can follow with no idle gap.
module uart_byte_tx
  import zhiwen_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_STOP = 4'd9;

  logic             r_active;
  logic [3:0]       r_bit_idx;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [8:0]       r_frame;
  logic             r_tx;

  logic w_bit_end;

  assign w_bit_end = (r_clk_cnt == CNT_LAST);
  assign done      = r_active && w_bit_end && (r_bit_idx == BIT_STOP);
  assign tx        = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      r_frame   <= '1;
      r_tx      <= 1'b1;
    end else if (start && (!r_active || done)) begin
      // r_frame holds the bits still to go: data LSB first, stop bit on top
      r_active  <= 1'b1;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      r_frame   <= {1'b1, data};
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (r_bit_idx == BIT_STOP) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_frame[0];
          r_frame   <= {1'b1, r_frame[8:1]};
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/zhiwen_cmd_tx.sv
// Sends the fixed command packet to the fingerprint sensor after a settle delay, repeating
// with a fixed gap while the synchronized enable stays high.
module zhiwen_cmd_tx
  import zhiwen_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 57600,
  parameter int unsigned START_DLY  = 50_000_000,
  parameter int unsigned REPEAT_GAP = 25_000_000,
  parameter logic [7:0]  CMD_CODE   = 8'h01
) (
  input  logic           clk,
  input  logic           rst_n,
  zhiwen_cmd_tx_if.slave cmd_if
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned DLY_W        = cnt_width(START_DLY);
  localparam int unsigned GAP_W        = cnt_width(REPEAT_GAP + 1);

  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(START_DLY - 1);
  // The frame_done cycle is spent in GAP too, so the gap runs one clock past REPEAT_GAP.
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(REPEAT_GAP);
  localparam logic [3:0]       LAST_BYTE = 4'(PKT_BYTES - 1);

  logic r_sync1;
  logic r_sync2;

  zw_state_e        r_state,      w_state_nxt;
  logic [DLY_W-1:0] r_dly_cnt,    w_dly_cnt_nxt;
  logic [GAP_W-1:0] r_gap_cnt,    w_gap_cnt_nxt;
  logic [3:0]       r_byte_idx,   w_byte_idx_nxt;
  logic             r_frame_done, w_frame_done_nxt;

  logic       w_byte_start;
  logic [7:0] w_byte_data;
  logic       w_byte_done;
  logic       w_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= cmd_if.tx_en;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dly_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_byte_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dly_cnt    <= w_dly_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_dly_cnt_nxt    = r_dly_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_byte_idx_nxt   = r_byte_idx;
    w_frame_done_nxt = 1'b0;
    w_byte_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2) begin
          w_state_nxt   = ST_WAIT;
          w_dly_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt   = ST_IDLE;
          w_dly_cnt_nxt = '0;
        end else if (r_dly_cnt == DLY_LAST) begin
          w_state_nxt    = ST_SEND;
          w_byte_idx_nxt = '0;
          w_byte_start   = 1'b1;
        end else begin
          w_dly_cnt_nxt = r_dly_cnt + DLY_W'(1);
        end
      end
      ST_SEND: begin
        // Enable is only looked at once the last stop bit has gone out.
        if (w_byte_done) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_frame_done_nxt = 1'b1;
            if (r_sync2) begin
              w_state_nxt   = ST_GAP;
              w_gap_cnt_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + 4'd1;
            w_byte_start   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!r_sync2) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt    = ST_SEND;
          w_byte_idx_nxt = '0;
          w_byte_start   = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Data follows the next index so a byte loads on the same edge its index is registered.
  assign w_byte_data = pkt_byte(w_byte_idx_nxt, CMD_CODE);

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_byte_start),
    .data (w_byte_data),
    .tx   (w_tx),
    .done (w_byte_done)
  );

  assign cmd_if.uart_tx    = w_tx;
  assign cmd_if.busy       = (r_state != ST_IDLE);
  assign cmd_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_zhiwen_cmd_tx.sv
// Directed bench: 16 clks/bit, START_DLY=40, REPEAT_GAP=30; dut_a sends GetImage, dut_b sends CMD 0xFF.
module tb_zhiwen_cmd_tx;

  localparam int CPB = 16;

  localparam logic [7:0] PKT_01 [12] = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                          8'h01, 8'h00, 8'h03, 8'h01, 8'h00, 8'h05};
  localparam logic [7:0] PKT_FF [12] = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                          8'h01, 8'h00, 8'h03, 8'hFF, 8'h01, 8'h03};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;
  logic sel   = 1'b0;

  zhiwen_cmd_tx_if if_a ();
  zhiwen_cmd_tx_if if_b ();

  assign if_a.tx_en = en_a;
  assign if_b.tx_en = en_b;

  zhiwen_cmd_tx #(
    .CLK_FREQ(16), .BAUD(1), .START_DLY(40), .REPEAT_GAP(30), .CMD_CODE(8'h01)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd_if(if_a.slave)
  );

  zhiwen_cmd_tx #(
    .CLK_FREQ(16), .BAUD(1), .START_DLY(40), .REPEAT_GAP(30), .CMD_CODE(8'hFF)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd_if(if_b.slave)
  );

  always #5 clk = ~clk;

  // edge_n = number of rising edges so far; stable when read on the falling edge
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  wire mon_line = sel ? if_b.uart_tx    : if_a.uart_tx;
  wire mon_fd   = sel ? if_b.frame_done : if_a.frame_done;

  int fd_cnt  = 0;
  int fd_edge = 0;
  always @(negedge clk) begin
    if (mon_fd === 1'b1) begin
      fd_cnt  <= fd_cnt + 1;
      fd_edge <= edge_n;
    end
  end

  logic [7:0] rx_q [$];
  int         start_q [$];
  int         frame_err = 0;

  initial begin : uart_mon
    logic [7:0] d;
    int         s;
    forever begin
      @(negedge clk);
      if (mon_line === 1'b0) begin
        s = edge_n;
        repeat (CPB / 2) @(negedge clk);
        if (mon_line !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = mon_line;
        end
        repeat (CPB) @(negedge clk);
        if (mon_line !== 1'b1) frame_err++;
        rx_q.push_back(d);
        start_q.push_back(s);
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic raise(output int ref_e);
    @(negedge clk);
    clear_mon();
    ref_e = edge_n;
    if (sel) en_b = 1'b1;
    else     en_a = 1'b1;
  endtask

  task automatic drop();
    if (sel) en_b = 1'b0;
    else     en_a = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic wait_fd(input int target_cnt, input int budget, input string tag);
    int n;
    n = 0;
    while (fd_cnt < target_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fd_cnt), 32'(target_cnt));
  endtask

  function automatic int rel_start(input int idx, input int ref_e);
    if (idx < start_q.size()) return start_q[idx] - ref_e;
    return -1;
  endfunction

  task automatic check_pkt(input int base, input bit alt, input string tag);
    logic [7:0] got;
    logic [7:0] want;
    for (int i = 0; i < 12; i++) begin
      want = alt ? PKT_FF[i] : PKT_01[i];
      got  = 'x;
      if (base + i < rx_q.size()) got = rx_q[base + i];
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, want});
    end
    $display("%s: packet at byte %0d checked, %0d bytes captured", tag, base, rx_q.size());
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r;
    int fb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_uart_tx_a",   32'(if_a.uart_tx),    32'd1);
    chk("rst_busy_a",      32'(if_a.busy),       32'd0);
    chk("rst_frame_done_a", 32'(if_a.frame_done), 32'd0);
    chk("rst_uart_tx_b",   32'(if_b.uart_tx),    32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("reset: outputs checked");

    // 1: single packet, enable dropped during byte 5
    raise(r);
    fb = fd_cnt;
    wait_to(r + 2);
    chk("t1_busy_edge2", 32'(if_a.busy), 32'd0);
    wait_to(r + 3);
    chk("t1_busy_edge3", 32'(if_a.busy), 32'd1);
    wait_to(r + 43 + 5 * 160 + 80);
    drop();
    wait_fd(fb + 1, 2500, "t1_frame_done_seen");
    chk("t1_frame_done_edge", 32'(fd_edge - r), 32'd1963);
    wait_to(r + 2200);
    chk("t1_start_edge", 32'(rel_start(0, r)), 32'd43);
    chk("t1_byte_count", 32'(rx_q.size()), 32'd12);
    check_pkt(0, 1'b0, "t1");
    chk("t1_frame_done_count", 32'(fd_cnt - fb), 32'd1);
    chk("t1_busy_after", 32'(if_a.busy), 32'd0);
    chk("t1_framing", 32'(frame_err), 32'd0);

    // 2: enable held, two packets
    raise(r);
    fb = fd_cnt;
    wait_fd(fb + 2, 4500, "t2_frame_done_seen");
    drop();
    chk("t2_frame_done2_edge", 32'(fd_edge - r), 32'd3914);
    wait_to(r + 4100);
    chk("t2_start_edge", 32'(rel_start(0, r)), 32'd43);
    chk("t2_repeat_period", 32'(rel_start(12, r) - rel_start(0, r)), 32'd1951);
    chk("t2_byte_count", 32'(rx_q.size()), 32'd24);
    check_pkt(0, 1'b0, "t2_pkt0");
    check_pkt(12, 1'b0, "t2_pkt1");
    chk("t2_busy_after", 32'(if_a.busy), 32'd0);

    // 3: abort in WAIT
    raise(r);
    fb = fd_cnt;
    wait_to(r + 20);
    drop();
    wait_to(r + 23);
    chk("t3_busy_fallen", 32'(if_a.busy), 32'd0);
    wait_to(r + 200);
    chk("t3_no_start_bit", 32'(start_q.size()), 32'd0);
    chk("t3_no_frame_done", 32'(fd_cnt - fb), 32'd0);
    $display("t3: abort in WAIT checked");

    // 4: abort 10 clocks into GAP
    raise(r);
    fb = fd_cnt;
    wait_fd(fb + 1, 2500, "t4_frame_done_seen");
    wait_to(fd_edge + 10);
    chk("t4_busy_in_gap", 32'(if_a.busy), 32'd1);
    drop();
    wait_to(fd_edge + 13);
    chk("t4_busy_fallen", 32'(if_a.busy), 32'd0);
    wait_to(r + 2300);
    chk("t4_byte_count", 32'(rx_q.size()), 32'd12);
    chk("t4_frame_done_count", 32'(fd_cnt - fb), 32'd1);
    $display("t4: abort in GAP checked");

    // 5: reset during byte 3, data bit 4
    raise(r);
    wait_to(r + 43 + 3 * 160 + 5 * CPB + 8);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_uart_tx", 32'(if_a.uart_tx), 32'd1);
    chk("t5_rst_busy", 32'(if_a.busy), 32'd0);
    chk("t5_rst_frame_done", 32'(if_a.frame_done), 32'd0);
    repeat (250) @(negedge clk);
    clear_mon();
    fb = fd_cnt;
    r = edge_n;
    rst_n = 1'b1;
    wait_fd(fb + 1, 2500, "t5_frame_done_seen");
    drop();
    chk("t5_frame_done_edge", 32'(fd_edge - r), 32'd1963);
    wait_to(r + 2200);
    chk("t5_start_edge", 32'(rel_start(0, r)), 32'd43);
    chk("t5_byte_count", 32'(rx_q.size()), 32'd12);
    check_pkt(0, 1'b0, "t5");

    // 6: checksum with CMD_CODE = 0xFF
    sel = 1'b1;
    repeat (2) @(negedge clk);
    raise(r);
    fb = fd_cnt;
    wait_fd(fb + 1, 2500, "t6_frame_done_seen");
    drop();
    wait_to(r + 2200);
    chk("t6_start_edge", 32'(rel_start(0, r)), 32'd43);
    chk("t6_byte_count", 32'(rx_q.size()), 32'd12);
    check_pkt(0, 1'b1, "t6");
    chk("t6_busy_after", 32'(if_b.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
